// File: rtl/arithmetic_left_shifter_seq_pkg.sv
// Shared constants and state encoding for the sequential shifters.
package arithmetic_left_shifter_seq_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned SHAMT_WIDTH = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StShift = S_SHIFT,
    StDone  = S_DONE
  } state_e;

endpackage

// File: rtl/arithmetic_left_shifter_seq_if.sv
// Start/done handshake and data bus between the control unit and the shifter.
interface arithmetic_left_shifter_seq_if
  import arithmetic_left_shifter_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_WIDTH,
  parameter int unsigned SHAMT_W = SHAMT_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;
  logic               overflow;

  // Requester side (control unit).
  modport master (
    output start, in, shamt,
    input  busy, done, out, overflow
  );

  // Shifter side.
  modport slave (
    input  start, in, shamt,
    output busy, done, out, overflow
  );

endinterface

// File: rtl/arithmetic_left_shifter_seq.sv
// Multi-cycle arithmetic left shifter: one bit per clock, signed-overflow detect.
module arithmetic_left_shifter_seq
  import arithmetic_left_shifter_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_WIDTH,
  parameter int unsigned SHAMT_W = SHAMT_WIDTH
) (
  input logic                         clk,
  input logic                         rst_n,
  arithmetic_left_shifter_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              overflow_q, overflow_d;

  logic [CNT_W-1:0]  cap_count;
  logic [WIDTH-1:0]  sreg_shl;
  logic              ovf_step;

  // Shifts beyond WIDTH produce the same result as WIDTH, so cap the iteration count.
  always_comb begin
    if (32'(bus.shamt) > WIDTH) begin
      cap_count = CNT_W'(WIDTH);
    end else begin
      cap_count = CNT_W'(bus.shamt);
    end
  end

  // The bit about to leave must match the new sign bit, otherwise the product has overflowed.
  always_comb begin
    sreg_shl = {sreg_q[WIDTH-2:0], 1'b0};
    ovf_step = sreg_q[WIDTH-1] ^ sreg_q[WIDTH-2];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = (cap_count == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (count_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    bus.busy = (state_q == StShift) || (state_q == StDone);
    bus.done = (state_q == StDone);
  end

  // Datapath next-state; out/overflow only load on the edge entering done.
  always_comb begin
    sreg_d     = sreg_q;
    count_d    = count_q;
    ovf_acc_d  = ovf_acc_q;
    out_d      = out_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sreg_d    = bus.in;
          count_d   = cap_count;
          ovf_acc_d = 1'b0;
          if (cap_count == '0) begin
            out_d      = bus.in;
            overflow_d = 1'b0;
          end
        end
      end
      StShift: begin
        sreg_d    = sreg_shl;
        count_d   = count_q - CNT_W'(1);
        ovf_acc_d = ovf_acc_q | ovf_step;
        if (count_q == CNT_W'(1)) begin
          out_d      = sreg_shl;
          overflow_d = ovf_acc_q | ovf_step;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q     <= '0;
      count_q    <= '0;
      ovf_acc_q  <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      count_q    <= count_d;
      ovf_acc_q  <= ovf_acc_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  // Drive the result bus from the held registers.
  always_comb begin
    bus.out      = out_q;
    bus.overflow = overflow_q;
  end

endmodule

// File: tb/tb_arithmetic_left_shifter_seq.sv
// Directed bench for the sequential arithmetic left shifter.
module tb_arithmetic_left_shifter_seq;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  logic [15:0] prev_out;

  arithmetic_left_shifter_seq_if #(.WIDTH(16), .SHAMT_W(5)) bus_if ();

  arithmetic_left_shifter_seq #(.WIDTH(16), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NVEC = 9;
  logic [15:0] vec_in   [NVEC] = '{16'h0011, 16'h4000, 16'hFFF0, 16'h1234, 16'h0001,
                                   16'h0003, 16'h8000, 16'hC000, 16'h0000};
  logic [4:0]  vec_sh   [NVEC] = '{5'd3, 5'd1, 5'd4, 5'd0, 5'd20, 5'd0, 5'd16, 5'd1, 5'd31};
  logic [15:0] vec_out  [NVEC] = '{16'h0088, 16'h8000, 16'hFF00, 16'h1234, 16'h0000,
                                   16'h0003, 16'h0000, 16'h8000, 16'h0000};
  logic        vec_ovf  [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int          vec_lat  [NVEC] = '{4, 2, 5, 1, 17, 1, 17, 2, 17};

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.in    = 16'hA5A5;
    bus_if.shamt = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus_if.busy); else passed++;
    total++; if (bus_if.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus_if.done); else passed++;
    total++; if (bus_if.out !== 16'h0000) $display("FAIL reset_out got %h want 0000", bus_if.out); else passed++;
    total++; if (bus_if.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus_if.overflow); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    prev_out = 16'h0000;
  endtask

  task automatic test_vectors();
    for (int i = 0; i < NVEC; i++) begin
      int lat;
      int bad_busy;
      int bad_hold;
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.in    = vec_in[i];
      bus_if.shamt = vec_sh[i];
      @(posedge clk);
      #1;
      // Operands may change freely once captured.
      bus_if.start = 1'b0;
      bus_if.in    = ~vec_in[i];
      bus_if.shamt = 5'd7;
      lat = 1;
      bad_busy = 0;
      bad_hold = 0;
      while (bus_if.done !== 1'b1 && lat < 40) begin
        if (bus_if.busy !== 1'b1) bad_busy++;
        if (bus_if.out !== prev_out) bad_hold++;
        @(posedge clk);
        #1;
        lat++;
      end
      total++; if (lat != vec_lat[i]) $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vec_lat[i]); else passed++;
      total++; if (bad_busy != 0) $display("FAIL vec%0d_busy_low_cycles got %0d want 0", i, bad_busy); else passed++;
      total++; if (bad_hold != 0) $display("FAIL vec%0d_out_changed_early got %0d want 0", i, bad_hold); else passed++;
      total++; if (bus_if.busy !== 1'b1) $display("FAIL vec%0d_busy_in_done got %b want 1", i, bus_if.busy); else passed++;
      total++; if (bus_if.out !== vec_out[i]) $display("FAIL vec%0d_out got %h want %h", i, bus_if.out, vec_out[i]); else passed++;
      total++; if (bus_if.overflow !== vec_ovf[i]) $display("FAIL vec%0d_ovf got %b want %b", i, bus_if.overflow, vec_ovf[i]); else passed++;
      @(posedge clk);
      #1;
      total++; if (bus_if.done !== 1'b0) $display("FAIL vec%0d_done_pulse got %b want 0", i, bus_if.done); else passed++;
      total++; if (bus_if.busy !== 1'b0) $display("FAIL vec%0d_idle_busy got %b want 0", i, bus_if.busy); else passed++;
      total++; if (bus_if.out !== vec_out[i]) $display("FAIL vec%0d_out_held got %h want %h", i, bus_if.out, vec_out[i]); else passed++;
      prev_out = vec_out[i];
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.in    = 16'h0003;
    bus_if.shamt = 5'd5;
    @(posedge clk);               // edge T
    #1;
    bus_if.start = 1'b0;
    @(posedge clk);               // edge T+1
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.in    = 16'h7FFF;
    bus_if.shamt = 5'd1;
    @(posedge clk);               // edge T+2, must be ignored
    #1;
    bus_if.start = 1'b0;
    lat = 3;
    while (bus_if.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++; if (lat != 6) $display("FAIL ignore_latency got %0d want 6", lat); else passed++;
    total++; if (bus_if.out !== 16'h0060) $display("FAIL ignore_out got %h want 0060", bus_if.out); else passed++;
    total++; if (bus_if.overflow !== 1'b0) $display("FAIL ignore_ovf got %b want 0", bus_if.overflow); else passed++;
    @(posedge clk);
    #1;
    total++; if (bus_if.busy !== 1'b0) $display("FAIL ignore_not_queued got %b want 0", bus_if.busy); else passed++;
  endtask

  task automatic test_abort();
    int done_seen;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.in    = 16'h0003;
    bus_if.shamt = 5'd5;
    @(posedge clk);               // edge T
    #1;
    bus_if.start = 1'b0;
    @(posedge clk);               // edge T+1
    @(posedge clk);               // edge T+2
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);               // edge T+3, reset sampled
    #1;
    total++; if (bus_if.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus_if.busy); else passed++;
    total++; if (bus_if.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus_if.done); else passed++;
    total++; if (bus_if.out !== 16'h0000) $display("FAIL abort_out got %h want 0000", bus_if.out); else passed++;
    total++; if (bus_if.overflow !== 1'b0) $display("FAIL abort_ovf got %b want 0", bus_if.overflow); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) done_seen++;
    end
    total++; if (done_seen != 0) $display("FAIL abort_no_done got %0d want 0", done_seen); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_vectors();
    test_start_ignored();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
